imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the CPU instruction-fetch port and the data-side read port (loads that target instruction space, e.g. constant tables).
- The ROM registers its word address on the clock edge, and its instruction output is valid in the following cycle.
- This block selects the requester each cycle, drives the ROM address, and routes the returned word to the owner with a valid pulse.
- A burst limit on the data port prevents fetch starvation.

Parameters:
- MAX_DATA_BURST, 4, maximum consecutive data-port grants while fetch is requesting; after this many, fetch receives one grant.
- CNT_W, 3, width of the burst counter; must satisfy 2^CNT_W > MAX_DATA_BURST.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  30  fetch word address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_valid  out  1  fetch data valid (registered owner tag)
- if_data  out  32  fetch data
- dr_req  in  1  data-read request
- dr_addr  in  30  data-read word address
- dr_gnt  out  1  data read granted this cycle (combinational)
- dr_valid  out  1  data-read data valid
- dr_data  out  32  data-read data
- rom_addr  out  30  word address to ROM (ROM registers it)
- rom_inst  in  32  ROM output word, valid the cycle after the address edge

Behaviour:
- Reset (asynchronous, active-high, on clk/rst):
  - owner register = NONE; burst counter = 0.
  - if_valid = 0 and dr_valid = 0.
  - if_data and dr_data = 0 while invalid.
  - rom_addr follows the idle rule below.
- Grant decision (combinational, at most one grant per cycle):
  - dr_req only: dr_gnt = 1.
  - if_req only: if_gnt = 1.
  - Both requesting: data wins while burst_cnt < MAX_DATA_BURST; otherwise fetch wins.
  - Neither requesting: no grant.
- rom_addr:
  - Equals dr_addr when dr_gnt = 1.
  - Otherwise equals if_addr, including when idle, so a speculative fetch read is harmless.
- Burst counter:
  - Increments on each dr_gnt that occurs while if_req = 1.
  - Clears on if_gnt, or on any cycle with if_req = 0.
  - Saturates at MAX_DATA_BURST; it never wraps.
- Owner register:
  - Set each cycle to FETCH (if_gnt), DATA (dr_gnt) or NONE (no grant).
- Response (one cycle after a grant):
  - if_valid = (owner == FETCH); dr_valid = (owner == DATA).
  - The matching data output = rom_inst; the non-owner data output = 0.
- Latency and throughput:
  - Fixed latency of 1 cycle from grant to valid.
  - Back-to-back grants are allowed, giving 1 word per cycle.
  - Responses arrive in grant order, with no reordering.
- Handshake:
  - A requester holds req and addr stable until it sees gnt.
  - addr may change in the cycle after gnt.
  - Dropping req before gnt is legal; nothing is issued.
- Boundary conditions:
  - Simultaneous requests with burst_cnt == MAX_DATA_BURST: fetch is granted and the counter clears.
  - Reset mid-transaction: the in-flight response is discarded (valid forced to 0); requesters re-issue.
  - Address wrap: 30-bit addresses are passed unmodified; the ROM returns 0 for unmapped words.
- State machine: owner register with states NONE, FETCH, DATA; every state may transition to any state each cycle per the grant logic.

Decomposition:
- Shared package, imem_pkg:
  - owner encoding typedef (NONE=2'b00, FETCH=2'b01, DATA=2'b10).
  - IMEM_ADDR_W = 30, IMEM_DATA_W = 32.
- Optional sub-module imem_burst_limiter: burst counter plus priority compare, outputs data_priority.
- No other sub-modules; the ROM is instantiated outside this block.

Test Plan:
- Reset, then if_req=1 with if_addr=0x0 → if_gnt in cycle 0, if_valid=1 in cycle 1 with if_data = word at 0x0 (0x3c1d1000); dr_valid stays 0.
- dr_req=1 at 0x2c with if_req=0 → dr_gnt, then dr_valid next cycle with dr_data=0x3c021001; if_valid=0.
- Both requesting continuously, MAX_DATA_BURST=4 → grant sequence D,D,D,D,F,D,D,D,D,F; each valid arrives 1 cycle after its grant with the correct word.
- Fetch streaming addresses 0x01–0x05 back-to-back, single dr_req at cycle 2 → fetch stalls one cycle (if_gnt=0 at cycle 2); data returned at cycle 3; fetch resumes with no lost or duplicated words.
- Assert rst in the cycle after a dr_gnt → dr_valid=0 immediately (async); burst_cnt=0; first grant after deassert is serviced normally.
- Address 0x3FFFFFFF requested → granted normally; returned data = 0x00000000.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and widths for the instruction-ROM arbiter.
// Owner encoding tags which requester's response is in flight.
package imem_pkg;

  localparam int IMEM_ADDR_W = 30;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } owner_e;

endpackage

// File: rtl/imem_burst_limiter.sv
// Counts consecutive data-port grants made while fetch waits.
// Data keeps priority only until the burst limit is reached.
module imem_burst_limiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int CNT_W          = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dr_gnt,
  output logic data_priority
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BURST);

  logic [CNT_W-1:0] burst_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      burst_cnt <= '0;
    end else if (dr_gnt && (burst_cnt != MAX_CNT)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign data_priority = (burst_cnt < MAX_CNT);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction ROM between fetch and data reads.
// Grants are combinational; responses return one cycle later, tagged by owner.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4,
  parameter int CNT_W          = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [IMEM_ADDR_W-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_valid,
  output logic [IMEM_DATA_W-1:0] if_data,
  input  logic                   dr_req,
  input  logic [IMEM_ADDR_W-1:0] dr_addr,
  output logic                   dr_gnt,
  output logic                   dr_valid,
  output logic [IMEM_DATA_W-1:0] dr_data,
  output logic [IMEM_ADDR_W-1:0] rom_addr,
  input  logic [IMEM_DATA_W-1:0] rom_inst
);

  owner_e owner_q;
  owner_e owner_d;
  logic   data_priority;

  imem_burst_limiter #(
    .MAX_DATA_BURST (MAX_DATA_BURST),
    .CNT_W          (CNT_W)
  ) u_burst_limiter (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_gnt        (if_gnt),
    .dr_gnt        (dr_gnt),
    .data_priority (data_priority)
  );

  // Data wins contention until the burst limit hands one slot to fetch.
  assign dr_gnt   = dr_req && (!if_req || data_priority);
  assign if_gnt   = if_req && !dr_gnt;
  // Idle cycles still present if_addr; a speculative ROM read is harmless.
  assign rom_addr = dr_gnt ? dr_addr : if_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_FETCH;
    end else if (dr_gnt) begin
      owner_d = OWN_DATA;
    end
  end

  always_comb begin
    if_valid = 1'b0;
    dr_valid = 1'b0;
    if_data  = '0;
    dr_data  = '0;
    unique case (owner_q)
      OWN_FETCH: begin
        if_valid = 1'b1;
        if_data  = rom_inst;
      end
      OWN_DATA: begin
        dr_valid = 1'b1;
        dr_data  = rom_inst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural ROM and a response scoreboard.
// Each cycle checks grants/rom_addr and the response owed from the previous grant.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dr_req;
  logic [29:0] if_addr, dr_addr;
  logic        if_gnt, if_valid, dr_gnt, dr_valid;
  logic [31:0] if_data, dr_data, rom_inst, rom_q;
  logic [29:0] rom_addr;

  typedef logic [65:0] resp_t;  // {if_valid, dr_valid, if_data, dr_data}
  resp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_data  (if_data),
    .dr_req   (dr_req),
    .dr_addr  (dr_addr),
    .dr_gnt   (dr_gnt),
    .dr_valid (dr_valid),
    .dr_data  (dr_data),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    if (a == 30'h0)          return 32'h3c1d1000;
    else if (a == 30'h2c)    return 32'h3c021001;
    else if (a < 30'h100)    return 32'h1000_0000 + {2'b00, a};
    else                     return 32'h0000_0000;
  endfunction

  // External ROM: address registered on the edge, word visible the next cycle.
  always @(posedge clk) rom_q <= rom_word(rom_addr);
  assign rom_inst = rom_q;

  task automatic chk_resp(input string tag);
    resp_t obs, exp;
    obs = {if_valid, dr_valid, if_data, dr_data};
    exp = (exp_q.size() == 0) ? resp_t'(0) : exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s resp observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at posedge+1, check at negedge, return the observed grant.
  task automatic cycle(input string tag, input logic ifr, input logic [29:0] ifa,
                       input logic drr, input logic [29:0] dra, output byte obs_g);
    byte   g;
    logic [31:0] exp_bus;
    if_req = ifr; if_addr = ifa; dr_req = drr; dr_addr = dra;
    @(negedge clk);
    chk_resp(tag);
    if (drr && (!ifr || m_cnt < 4)) g = "D";
    else if (ifr)                   g = "F";
    else                            g = "N";
    obs_g = (if_gnt && dr_gnt) ? "B" : dr_gnt ? "D" : if_gnt ? "F" : "N";
    exp_bus = {2'b00, (g == "D") ? dra : ifa};
    checks++;
    assert ({if_gnt, dr_gnt, rom_addr} === {g == "F", g == "D", exp_bus[29:0]}) else begin
      failures++;
      $error("FAIL %s gnt observed=%b%b/%h expected=%b%b/%h", tag, if_gnt, dr_gnt, rom_addr,
             g == "F", g == "D", exp_bus[29:0]);
    end
    case (g)
      "F":     exp_q.push_back({2'b10, rom_word(ifa), 32'h0});
      "D":     exp_q.push_back({2'b01, 32'h0, rom_word(dra)});
      default: exp_q.push_back('0);
    endcase
    if (!ifr || g == "F")          m_cnt = 0;
    else if (g == "D" && m_cnt < 4) m_cnt = m_cnt + 1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; dr_req = 1'b0;
    if_addr = 30'h155; dr_addr = 30'h2aa;
    #1;
    checks++;
    assert ({if_valid, dr_valid, if_data, dr_data} === 66'h0) else begin
      failures++;
      $error("FAIL reset_outputs observed=%b%b/%h/%h expected=0", if_valid, dr_valid, if_data, dr_data);
    end
    checks++;
    assert (rom_addr === 30'h155) else begin
      failures++;
      $error("FAIL reset_rom_addr observed=%h expected=155", rom_addr);
    end
    exp_q.delete();
    exp_q.push_back('0);
    m_cnt = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    byte   g;
    string pat;
    logic [29:0] fa, da;
    logic  dr_pend;
    int    c;

    if_req = 1'b0; dr_req = 1'b0; if_addr = '0; dr_addr = '0;
    #2;
    do_reset();

    // Single fetch at 0x0, then single data read at 0x2c.
    cycle("if0", 1'b1, 30'h0, 1'b0, 30'h0, g);
    cycle("if0_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);
    cycle("dr2c", 1'b0, 30'h5, 1'b1, 30'h2c, g);
    cycle("dr2c_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);

    // Continuous contention: burst limit lets fetch in every fifth grant.
    pat = "DDDDFDDDDF";
    fa = 30'h10; da = 30'h20;
    for (int i = 0; i < 10; i++) begin
      cycle("burst", 1'b1, fa, 1'b1, da, g);
      checks++;
      assert (g === pat[i]) else begin
        failures++;
        $error("FAIL burst_seq[%0d] observed=%c expected=%c", i, g, pat[i]);
      end
      if (g == "F") fa = fa + 1'b1;
      if (g == "D") da = da + 1'b1;
    end
    cycle("burst_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);

    // Fetch stream 0x01..0x05 with one data read inserted at cycle 2.
    fa = 30'h1; dr_pend = 1'b0; c = 0;
    while (fa <= 30'h5 && c < 20) begin
      if (c == 2) dr_pend = 1'b1;
      cycle("stall", 1'b1, fa, dr_pend, 30'h2c, g);
      if (c == 2) begin
        checks++;
        assert (g === "D") else begin
          failures++;
          $error("FAIL stall_cycle2 observed=%c expected=D", g);
        end
      end
      if (g == "D") dr_pend = 1'b0;
      if (g == "F") fa = fa + 1'b1;
      c++;
    end
    checks++;
    assert (fa === 30'h6 && c === 6) else begin
      failures++;
      $error("FAIL stall_progress observed=fa %h cycles %0d expected=fa 6 cycles 6", fa, c);
    end
    cycle("stall_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);

    // Build up the burst counter, reset with a data response in flight.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 30'h30, 1'b1, 30'h40 + 30'(i), g);
    checks++;
    assert (dr_valid === 1'b1) else begin
      failures++;
      $error("FAIL pre_rst_valid observed=%b expected=1", dr_valid);
    end
    do_reset();
    fa = 30'h30; da = 30'h50;
    for (int i = 0; i < 5; i++) begin
      cycle("post_rst", 1'b1, fa, 1'b1, da, g);
      checks++;
      assert (g === pat[i]) else begin
        failures++;
        $error("FAIL post_rst_seq[%0d] observed=%c expected=%c", i, g, pat[i]);
      end
      if (g == "F") fa = fa + 1'b1;
      if (g == "D") da = da + 1'b1;
    end
    cycle("post_rst_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);

    // Top-of-range address on both ports: passed through, unmapped word reads 0.
    cycle("wrap_if", 1'b1, 30'h3FFFFFFF, 1'b0, 30'h0, g);
    cycle("wrap_dr", 1'b0, 30'h0, 1'b1, 30'h3FFFFFFF, g);
    cycle("wrap_rsp", 1'b0, 30'h0, 1'b0, 30'h0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
